// File: rtl/cache_tag_valid_array.sv
// Per-way tag/valid storage for one set-associative cache.
// Registered one-cycle read with a read-first hold when CacheEn is low,
// fill/invalidate writes, and a whole-cache invalidate sweep.
// Optional macro TAGARRAY_PARITY_EN adds an even-parity bit per tag entry
// and the TagParityErr output.
module cache_tag_valid_array #(
  parameter int NUMWAYS  = 4,
  parameter int NUMLINES = 128,
  parameter int SETLEN   = 7,
  parameter int TAGLEN   = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CacheEn,
  input  logic [SETLEN-1:0]  CacheSet,
  input  logic [TAGLEN-1:0]  PAdrTag,
  input  logic [SETLEN-1:0]  WriteSet,
  input  logic [NUMWAYS-1:0] WriteWay,
  input  logic               SetValid,
  input  logic               ClearValid,
  input  logic               InvalidateCache,
  output logic [NUMWAYS-1:0] HitWay,
  output logic [NUMWAYS-1:0] ValidWay,
  output logic               Hit,
  output logic               InvalidateBusy
`ifdef TAGARRAY_PARITY_EN
  ,
  output logic               TagParityErr
`endif
);

`ifdef TAGARRAY_PARITY_EN
  localparam int TAGW = TAGLEN + 1;
`else
  localparam int TAGW = TAGLEN;
`endif

  localparam logic [SETLEN-1:0] LAST_SET = SETLEN'(NUMLINES - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_reg;
  logic [SETLEN-1:0]   sweep_cnt_reg;
  logic                busy_reg;

  logic [NUMWAYS-1:0]  set_way;
  logic [NUMWAYS-1:0]  clr_way;
  logic [NUMWAYS-1:0]  tag_we;
  logic [NUMWAYS-1:0]  valid_rd;
  logic [NUMWAYS-1:0]  tag_match;
  logic [TAGW-1:0]     tag_wdata;
`ifdef TAGARRAY_PARITY_EN
  logic [NUMWAYS-1:0]  par_err;
`endif

  // Sweep FSM: walks every set once, one set per cycle, then returns to idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      sweep_cnt_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (InvalidateCache) begin
            state_reg     <= SWEEP;
            sweep_cnt_reg <= '0;
            busy_reg      <= 1'b1;
          end
        end
        SWEEP: begin
          if (sweep_cnt_reg == LAST_SET) begin
            state_reg     <= IDLE;
            sweep_cnt_reg <= '0;
            busy_reg      <= 1'b0;
          end else begin
            sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          sweep_cnt_reg <= '0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  // Writes are dropped while sweeping; clear beats set on the same way
  assign set_way = WriteWay & {NUMWAYS{SetValid & ~busy_reg}};
  assign clr_way = WriteWay & {NUMWAYS{ClearValid & ~busy_reg}};
  assign tag_we  = set_way & ~clr_way;

`ifdef TAGARRAY_PARITY_EN
  assign tag_wdata = {^PAdrTag, PAdrTag};
`else
  assign tag_wdata = PAdrTag;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUMWAYS; gi++) begin : g_way
      logic [NUMLINES-1:0] valid_reg;
      logic                valid_rd_reg;
      logic [TAGW-1:0]     tag_mem [NUMLINES];
      logic [TAGW-1:0]     tag_rd_reg;

      // Valid bits and their read register; the read samples pre-write state
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_reg    <= '0;
          valid_rd_reg <= 1'b0;
        end else begin
          if (CacheEn) begin
            valid_rd_reg <= valid_reg[CacheSet];
          end
          if (busy_reg) begin
            valid_reg[sweep_cnt_reg] <= 1'b0;
          end else if (clr_way[gi]) begin
            valid_reg[WriteSet] <= 1'b0;
          end else if (set_way[gi]) begin
            valid_reg[WriteSet] <= 1'b1;
          end
        end
      end

      // Tag RAM with registered, read-first output held while CacheEn is low
      always_ff @(posedge clk) begin
        if (tag_we[gi]) begin
          tag_mem[WriteSet] <= tag_wdata;
        end
        if (CacheEn) begin
          tag_rd_reg <= tag_mem[CacheSet];
        end
      end

      assign valid_rd[gi]  = valid_rd_reg;
      assign tag_match[gi] = (tag_rd_reg[TAGLEN-1:0] == PAdrTag);
`ifdef TAGARRAY_PARITY_EN
      assign par_err[gi]   = ^tag_rd_reg;
`endif
    end
  endgenerate

  assign ValidWay       = valid_rd & {NUMWAYS{~busy_reg}};
`ifdef TAGARRAY_PARITY_EN
  assign HitWay         = ValidWay & tag_match & ~par_err;
  assign TagParityErr   = |(ValidWay & par_err);
`else
  assign HitWay         = ValidWay & tag_match;
`endif
  assign Hit            = |HitWay;
  assign InvalidateBusy = busy_reg;

endmodule

// File: tb/tb_cache_tag_valid_array.sv
// Bench for cache_tag_valid_array: directed test-plan sequence followed by
// randomized traffic, all checked against a set/way array reference model.
module tb_cache_tag_valid_array;
  localparam int NW = 4;
  localparam int NL = 128;
  localparam int SL = 7;
  localparam int TL = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          CacheEn;
  logic [SL-1:0] CacheSet;
  logic [TL-1:0] PAdrTag;
  logic [SL-1:0] WriteSet;
  logic [NW-1:0] WriteWay;
  logic          SetValid;
  logic          ClearValid;
  logic          InvalidateCache;
  logic [NW-1:0] HitWay;
  logic [NW-1:0] ValidWay;
  logic          Hit;
  logic          InvalidateBusy;
`ifdef TAGARRAY_PARITY_EN
  logic          TagParityErr;
`endif

  always #5 clk = ~clk;

  cache_tag_valid_array #(.NUMWAYS(NW), .NUMLINES(NL), .SETLEN(SL), .TAGLEN(TL)) dut (
    .clk(clk), .reset(reset), .CacheEn(CacheEn), .CacheSet(CacheSet),
    .PAdrTag(PAdrTag), .WriteSet(WriteSet), .WriteWay(WriteWay),
    .SetValid(SetValid), .ClearValid(ClearValid), .InvalidateCache(InvalidateCache),
    .HitWay(HitWay), .ValidWay(ValidWay), .Hit(Hit), .InvalidateBusy(InvalidateBusy)
`ifdef TAGARRAY_PARITY_EN
    , .TagParityErr(TagParityErr)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: cache contents as plain arrays plus the last read snapshot
  bit            m_valid [NW][NL];
  logic [TL-1:0] m_tag   [NW][NL];
  bit            m_pbad  [NW][NL];
  bit            rd_valid [NW];
  logic [TL-1:0] rd_tag   [NW];
  bit            rd_pbad  [NW];
  int            sweep_left = 0;
  int            sweep_idx  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      for (int s = 0; s < NL; s++) m_valid[w][s] = 1'b0;
      rd_valid[w] = 1'b0;
    end
    sweep_left = 0;
    sweep_idx  = 0;
  endtask

  // Applies one clock edge worth of behaviour using the inputs as driven now
  task automatic model_edge();
    if (CacheEn) begin
      for (int w = 0; w < NW; w++) begin
        rd_valid[w] = m_valid[w][CacheSet];
        rd_tag[w]   = m_tag[w][CacheSet];
        rd_pbad[w]  = m_pbad[w][CacheSet];
      end
    end
    if (sweep_left > 0) begin
      for (int w = 0; w < NW; w++) m_valid[w][sweep_idx] = 1'b0;
      sweep_idx++;
      sweep_left--;
    end else begin
      if (InvalidateCache) begin
        sweep_left = NL;
        sweep_idx  = 0;
      end
      for (int w = 0; w < NW; w++) begin
        if (ClearValid && WriteWay[w]) begin
          m_valid[w][WriteSet] = 1'b0;
        end else if (SetValid && WriteWay[w]) begin
          m_valid[w][WriteSet] = 1'b1;
          m_tag[w][WriteSet]   = PAdrTag;
          m_pbad[w][WriteSet]  = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string n);
    logic [NW-1:0] ev, eh;
    logic          ep;
    ev = '0; eh = '0; ep = 1'b0;
    if (sweep_left == 0) begin
      for (int w = 0; w < NW; w++) begin
        ev[w] = rd_valid[w];
        eh[w] = rd_valid[w] && (rd_tag[w] == PAdrTag) && !rd_pbad[w];
        ep    = ep | (rd_valid[w] && rd_pbad[w]);
      end
    end
    check({n, ".valid"}, 32'(ValidWay), 32'(ev));
    check({n, ".hitway"}, 32'(HitWay), 32'(eh));
    check({n, ".hit"}, 32'(Hit), 32'(|eh));
    check({n, ".busy"}, 32'(InvalidateBusy), 32'(sweep_left > 0));
`ifdef TAGARRAY_PARITY_EN
    check({n, ".parerr"}, 32'(TagParityErr), 32'(ep));
`else
    if (ep) check({n, ".parerr_model"}, 32'(ep), 32'(0));
`endif
  endtask

  task automatic step(input string n);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(n);
  endtask

  task automatic idle_inputs();
    SetValid = 1'b0; ClearValid = 1'b0; InvalidateCache = 1'b0;
    WriteWay = '0;
  endtask

  task automatic fill(input int set, input logic [NW-1:0] way, input logic [TL-1:0] tag);
    idle_inputs();
    CacheEn = 1'b0;
    SetValid = 1'b1; WriteSet = SL'(set); WriteWay = way; PAdrTag = tag;
    step("fill");
    idle_inputs();
  endtask

  task automatic read(input string n, input int set, input logic [TL-1:0] tag);
    idle_inputs();
    CacheEn = 1'b1; CacheSet = SL'(set); PAdrTag = tag;
    step(n);
  endtask

  logic [TL-1:0] tag_pool [4];
  int            busy_cnt;

  initial begin
    tag_pool[0] = 20'h12345; tag_pool[1] = 20'hABCDE;
    tag_pool[2] = 20'h00001; tag_pool[3] = 20'hFFFFF;
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < NL; s++) begin
        m_tag[w][s]  = '0;
        m_pbad[w][s] = 1'b0;
      end
    for (int w = 0; w < NW; w++) begin rd_tag[w] = '0; rd_pbad[w] = 1'b0; end

    reset = 1'b0; CacheEn = 1'b0; CacheSet = '0; PAdrTag = '0; WriteSet = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("in_reset");
    reset = 1'b1;

    // Reset then read
    read("rst_read", 5, 20'h12345);
    check("rst_read.valid0", 32'(ValidWay), 32'h0);
    check("rst_read.busy0", 32'(InvalidateBusy), 32'h0);

    // Fill and hit
    fill(5, 4'b0100, 20'h12345);
    read("hit_read", 5, 20'h12345);
    check("hit.valid", 32'(ValidWay), 32'h4);
    check("hit.hitway", 32'(HitWay), 32'h4);
    check("hit.hit", 32'(Hit), 32'h1);
    PAdrTag = 20'h12346;
    #1;
    check_outputs("miss_tag");
    check("miss.hit", 32'(Hit), 32'h0);

    // Read-first: read and clear the same set in one edge, then hold
    PAdrTag = 20'h12345; CacheEn = 1'b1; CacheSet = SL'(5);
    ClearValid = 1'b1; WriteSet = SL'(5); WriteWay = 4'b0100;
    step("rdfirst");
    check("rdfirst.valid", 32'(ValidWay), 32'h4);
    idle_inputs(); CacheEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("hold");
      check("hold.valid", 32'(ValidWay), 32'h4);
    end
    read("reread", 5, 20'h12345);
    check("reread.valid", 32'(ValidWay), 32'h0);

    // Set/clear conflicts on set 9
    fill(9, 4'b0001, 20'h0AAAA);
    CacheEn = 1'b0; SetValid = 1'b1; ClearValid = 1'b1;
    WriteSet = SL'(9); WriteWay = 4'b0001; PAdrTag = 20'h0BBBB;
    step("conflict_same");
    read("conflict_same_rd", 9, 20'h0BBBB);
    check("conflict_same.valid", 32'(ValidWay), 32'h0);
    fill(9, 4'b0001, 20'h0CCCC);
    CacheEn = 1'b0; SetValid = 1'b1; ClearValid = 1'b1;
    WriteSet = SL'(9); WriteWay = 4'b0010; PAdrTag = 20'h0DDDD;
    step("conflict_diff");
    read("conflict_diff_rd", 9, 20'h0CCCC);
    check("conflict_diff.valid", 32'(ValidWay), 32'h1);

    // Sweep with writes attempted throughout
    fill(0, 4'b1111, 20'h11111);
    fill(64, 4'b1111, 20'h22222);
    fill(127, 4'b1111, 20'h33333);
    idle_inputs(); CacheEn = 1'b0; InvalidateCache = 1'b1;
    step("sweep_start");
    InvalidateCache = 1'b0;
    busy_cnt = 0;
    while (InvalidateBusy && busy_cnt < 200) begin
      busy_cnt++;
      SetValid = 1'b1; WriteSet = SL'(busy_cnt % 8); WriteWay = 4'b0001;
      PAdrTag = 20'h44444;
      step("sweep");
    end
    check("sweep.cycles", 32'(busy_cnt), 32'd128);
    idle_inputs();
    read("post_sweep0", 0, 20'h11111);
    check("post_sweep0.valid", 32'(ValidWay), 32'h0);
    read("post_sweep64", 64, 20'h22222);
    read("post_sweep127", 127, 20'h33333);
    read("post_sweep3", 3, 20'h44444);

    // Reset in the middle of a sweep
    fill(10, 4'b1010, 20'h55555);
    InvalidateCache = 1'b1;
    step("sweep2_start");
    InvalidateCache = 1'b0;
    for (int i = 0; i < 40; i++) step("sweep2");
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_reset");
    check("mid_reset.busy", 32'(InvalidateBusy), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    read("after_reset10", 10, 20'h55555);
    check("after_reset10.valid", 32'(ValidWay), 32'h0);

`ifdef TAGARRAY_PARITY_EN
    fill(3, 4'b0010, 20'h12345);
    fill(4, 4'b0001, 20'h12345);
    dut.g_way[1].tag_mem[3][0] = ~dut.g_way[1].tag_mem[3][0];
    m_pbad[1][3] = 1'b1;
    read("par_bad", 3, 20'h12345);
    check("par_bad.hitway", 32'(HitWay), 32'h0);
    check("par_bad.err", 32'(TagParityErr), 32'h1);
    read("par_clean", 4, 20'h12345);
    check("par_clean.err", 32'(TagParityErr), 32'h0);
`endif

    // Randomized traffic over a small set window so hits are frequent
    for (int i = 0; i < 600; i++) begin
      CacheEn    = ($urandom_range(0, 3) != 0);
      CacheSet   = SL'($urandom_range(0, 7));
      PAdrTag    = tag_pool[$urandom_range(0, 3)];
      WriteSet   = SL'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       WriteWay = '0;
        5:       WriteWay = NW'($urandom);
        default: WriteWay = NW'(1) << $urandom_range(0, NW - 1);
      endcase
      SetValid        = ($urandom_range(0, 9) < 4);
      ClearValid      = ($urandom_range(0, 9) < 2);
      InvalidateCache = ($urandom_range(0, 199) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
